// File: rtl/q_sample_player.sv
// Q-factor sample table player: RAM-backed table streamed over valid/ready at a
// programmable rate, once or looped, with a saturating count of missed rate ticks.
module q_sample_player #(
    parameter int unsigned Q_WIDTH = 16,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned DIV_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [Q_WIDTH-1:0] wr_data,
    input  logic [ADDR_W:0]    len,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    output logic               q_valid,
    input  logic               q_ready,
    output logic [Q_WIDTH-1:0] q_data,
    output logic [ADDR_W-1:0]  q_index,
    output logic               busy,
    output logic               done,
    output logic [7:0]         miss_cnt
);

    typedef enum logic [1:0] {StIdle, StRun, StFetch, StPresent} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                q_valid_q, q_valid_d;
    logic [Q_WIDTH-1:0]  q_data_q, q_data_d;
    logic [ADDR_W-1:0]   q_index_q, q_index_d;
    logic                done_q, done_d;
    logic [7:0]          miss_q, miss_d;

    logic [Q_WIDTH-1:0]  mem [DEPTH];
    logic [Q_WIDTH-1:0]  rd_data_q;
    logic                rd_en;
    logic                tick;
    logic                last;

    assign tick = (cnt_q == div_q);
    assign last = ({1'b0, idx_q} == (len_q - 1'b1));

    // Table RAM: nonblocking read and write on the same edge gives read-before-write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start && len != '0) state_d = StRun;
            StRun:     if (tick) state_d = StFetch;
            StFetch:   state_d = StPresent;
            StPresent: if (q_ready) state_d = (last && !loop_en) ? StIdle : StRun;
            default:   state_d = StIdle;
        endcase
        // stop wins over start in IDLE and over a handshake elsewhere
        if (stop) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        len_d     = len_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        q_valid_d = q_valid_q;
        q_data_d  = q_data_q;
        q_index_d = q_index_q;
        miss_d    = miss_q;
        done_d    = 1'b0;
        rd_en     = 1'b0;
        if (state_q == StIdle) begin
            if (start && !stop) begin
                if (len != '0) begin
                    len_d  = len;
                    div_d  = rate_div;
                    idx_d  = '0;
                    cnt_d  = '0;
                    miss_d = '0;
                end else begin
                    done_d = 1'b1;
                end
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (stop) begin
                q_valid_d = 1'b0;
            end else begin
                if (tick && state_q != StRun && miss_q != 8'hff) begin
                    miss_d = miss_q + 1'b1;
                end
                unique case (state_q)
                    StRun: rd_en = tick;
                    StFetch: begin
                        q_data_d  = rd_data_q;
                        q_index_d = idx_q;
                        q_valid_d = 1'b1;
                    end
                    StPresent: begin
                        if (q_ready) begin
                            q_valid_d = 1'b0;
                            if (!last) begin
                                idx_d = idx_q + 1'b1;
                            end else if (loop_en) begin
                                idx_d = '0;
                            end else begin
                                done_d = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q     <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            q_valid_q <= 1'b0;
            q_data_q  <= '0;
            q_index_q <= '0;
            done_q    <= 1'b0;
            miss_q    <= '0;
        end else begin
            len_q     <= len_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            q_valid_q <= q_valid_d;
            q_data_q  <= q_data_d;
            q_index_q <= q_index_d;
            done_q    <= done_d;
            miss_q    <= miss_d;
        end
    end

    assign q_valid  = q_valid_q;
    assign q_data   = q_data_q;
    assign q_index  = q_index_q;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;
    assign miss_cnt = miss_q;

endmodule
